truth_table_checker: RTL and testbench

- Synthesizable stimulus-and-response engine for three-input combinational blocks.
- On `start`, it drives all eight `{a,b,c}` combinations in order to the DUT.
- For each combination it waits a fixed settle time, samples the DUT output and compares it against an expected truth table.
- At the end it reports pass/fail, the mismatch count and the first failing vector. It sits beside the combinational DUT as its on-chip checker.

---
 rtl/truth_table_checker_if.sv | 33 +++
 rtl/truth_table_checker.sv | 119 +++++++++++
 tb/tb_truth_table_checker.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_checker_if.sv
// ============================================================================
// Module      : truth_table_checker_if
// Description : Stimulus/response bundle between truth_table_checker and the
//               combinational block it exercises.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface truth_table_checker_if;
   logic       start;
   logic       dut_out;
   logic       a;
   logic       b;
   logic       c;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_count;
   logic       fail_valid;
   logic [2:0] first_fail_idx;

   modport master (
      input  start, dut_out,
      output a, b, c, busy, done, pass, err_count, fail_valid, first_fail_idx
   );

   modport slave (
      output start, dut_out,
      input  a, b, c, busy, done, pass, err_count, fail_valid, first_fail_idx
   );
endinterface

`default_nettype wire

// File: rtl/truth_table_checker.sv
// ============================================================================
// Module      : truth_table_checker
// Description : Walks all eight {a,b,c} vectors through a 3-input block and
//               checks each response against the EXPECTED truth table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_checker #(
   parameter logic [7:0] EXPECTED = 8'b1110_1000,
   parameter int         SETTLE   = 2
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   truth_table_checker_if.master tt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] c_CNT_RELOAD = 4'(SETTLE - 1);

   state_t     r_state;
   logic [2:0] r_idx;
   logic [3:0] r_cnt;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;
   logic [3:0] r_err;
   logic       r_fail_valid;
   logic [2:0] r_first_fail;

   logic       w_mismatch;
   logic [3:0] w_err_nxt;

   assign w_mismatch = (tt.dut_out != EXPECTED[r_idx]);
   assign w_err_nxt  = r_err + {3'b000, w_mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_idx        <= 3'd0;
         r_cnt        <= 4'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= 4'd0;
         r_fail_valid <= 1'b0;
         r_first_fail <= 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (tt.start) begin
                  r_idx        <= 3'd0;
                  r_cnt        <= c_CNT_RELOAD;
                  r_busy       <= 1'b1;
                  r_pass       <= 1'b0;
                  r_err        <= 4'd0;
                  r_fail_valid <= 1'b0;
                  r_first_fail <= 3'd0;
                  r_state      <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_SAMPLE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_SAMPLE: begin
               r_err <= w_err_nxt;
               if (w_mismatch && !r_fail_valid) begin
                  r_fail_valid <= 1'b1;
                  r_first_fail <= r_idx;
               end
               // The vector register doubles as the index, so it holds 3'b111 after the run
               if (r_idx != 3'd7) begin
                  r_idx   <= r_idx + 3'd1;
                  r_cnt   <= c_CNT_RELOAD;
                  r_state <= S_SETTLE;
               end else begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_nxt == 4'd0);
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign tt.a              = r_idx[2];
   assign tt.b              = r_idx[1];
   assign tt.c              = r_idx[0];
   assign tt.busy           = r_busy;
   assign tt.done           = r_done;
   assign tt.pass           = r_pass;
   assign tt.err_count      = r_err;
   assign tt.fail_valid     = r_fail_valid;
   assign tt.first_fail_idx = r_first_fail;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_checker.sv
// ============================================================================
// Module      : tb_truth_table_checker
// Description : Directed bench for truth_table_checker (SETTLE=2 and SETTLE=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_checker;

   localparam logic [7:0] c_EXP = 8'b1110_1000;

   logic clk = 1'b0;
   logic rst_n;
   logic start_v [2];
   int   mode2;
   bit   cmp_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   truth_table_checker_if if2 ();
   truth_table_checker_if if1 ();

   // Response of the block under test: 0 majority, 1 stuck-at-0, 2 inverted majority
   function automatic bit dut_fn(int mode, int v);
      logic [2:0] vv;
      bit maj;
      vv  = 3'(v);
      maj = ($countones(vv) >= 2);
      if (mode == 1) return 1'b0;
      if (mode == 2) return !maj;
      return maj;
   endfunction

   assign if2.start   = start_v[0];
   assign if1.start   = start_v[1];
   assign if2.dut_out = dut_fn(mode2, int'({if2.a, if2.b, if2.c}));
   assign if1.dut_out = dut_fn(0, int'({if1.a, if1.b, if1.c}));

   truth_table_checker #(.EXPECTED(c_EXP), .SETTLE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .tt(if2.master)
   );
   truth_table_checker #(.EXPECTED(c_EXP), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tt(if1.master)
   );

   // {abc[13:11], busy[10], done[9], pass[8], err[7:4], fail_valid[3], first[2:0]}
   logic [13:0] act [2];
   assign act[0] = {if2.a, if2.b, if2.c, if2.busy, if2.done, if2.pass,
                    if2.err_count, if2.fail_valid, if2.first_fail_idx};
   assign act[1] = {if1.a, if1.b, if1.c, if1.busy, if1.done, if1.pass,
                    if1.err_count, if1.fail_valid, if1.first_fail_idx};

   function automatic int settle_of(int k);
      return (k == 0) ? 2 : 1;
   endfunction

   // Model: time since the accepting edge determines everything
   bit m_run  [2];
   bit m_dcyc [2];
   bit m_ran  [2];
   int m_t    [2];
   int m_mode [2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_run[k] = 0; m_dcyc[k] = 0; m_ran[k] = 0; m_t[k] = 0; m_mode[k] = 0;
         end else if (m_run[k]) begin
            m_t[k] = m_t[k] + 1;
            if (m_t[k] == 8 * (settle_of(k) + 1)) begin
               m_run[k]  = 0;
               m_dcyc[k] = 1;
            end
         end else if (m_dcyc[k]) begin
            m_dcyc[k] = 0;
         end else if (start_v[k]) begin
            m_run[k]  = 1;
            m_t[k]    = 0;
            m_ran[k]  = 1;
            m_mode[k] = (k == 0) ? mode2 : 0;
         end
      end
   end

   function automatic logic [13:0] expected_of(int k);
      int n, err, first, period;
      bit fv, busy, done, pass;
      int vec;
      if (!m_ran[k]) return 14'd0;
      period = settle_of(k) + 1;
      if (m_run[k]) begin
         n = m_t[k] / period; vec = n; busy = 1; done = 0;
      end else begin
         n = 8; vec = 7; busy = 0; done = m_dcyc[k];
      end
      err = 0; fv = 0; first = 0;
      for (int i = 0; i < n; i++) begin
         if (dut_fn(m_mode[k], i) != c_EXP[i]) begin
            if (!fv) first = i;
            fv  = 1;
            err = err + 1;
         end
      end
      pass = !m_run[k] && (err == 0);
      return {3'(vec), busy, done, pass, 4'(err), fv, 3'(first)};
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < 2; k++) begin
            logic [13:0] e;
            e = expected_of(k);
            n_cmp++;
            if (act[k] !== e) begin
               n_bad++;
               $display("FAIL cycle[inst%0d] @%0t: actual=%b required=%b", k, $time, act[k], e);
            end
         end
      end
   end

   task automatic chk(string nm, int a, int e);
      n_cmp++;
      if (a != e) begin
         n_bad++;
         $display("FAIL %s: actual=%0d required=%0d", nm, a, e);
      end
   endtask

   // Pulse start on instance k and count edges from acceptance until done is seen
   task automatic run(int k, bit glitch, output int edges, output int err0);
      @(negedge clk);
      start_v[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[k] = 1'b0;
      err0  = int'(act[k][7:4]);
      edges = 0;
      while (1) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (act[k][9]) break;
         start_v[k] = glitch && (edges == 4 || edges == 23);
         if (edges > 100) begin
            chk("run_timeout", edges, -1);
            break;
         end
      end
      start_v[k] = 1'b0;
   endtask

   initial begin
      int edges, err0, dn;
      rst_n = 1'b0; start_v[0] = 1'b0; start_v[1] = 1'b0; mode2 = 0;
      repeat (2) @(negedge clk);
      chk("reset_state2", int'(act[0]), 0);
      chk("reset_state1", int'(act[1]), 0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);

      run(0, 0, edges, err0);
      chk("maj_done_edge", edges, 24);
      chk("maj_pass", int'(if2.pass), 1);
      chk("maj_err", int'(if2.err_count), 0);
      chk("maj_abc_hold", int'({if2.a, if2.b, if2.c}), 7);

      mode2 = 1;
      run(0, 0, edges, err0);
      chk("zero_err", int'(if2.err_count), 4);
      chk("zero_first", int'(if2.first_fail_idx), 3);
      chk("zero_fv", int'(if2.fail_valid), 1);
      chk("zero_pass", int'(if2.pass), 0);

      mode2 = 2;
      run(0, 0, edges, err0);
      chk("inv_err", int'(if2.err_count), 8);
      chk("inv_first", int'(if2.first_fail_idx), 0);
      chk("inv_pass", int'(if2.pass), 0);

      mode2 = 0;
      run(0, 0, edges, err0);
      chk("rerun_err_cleared", err0, 0);
      chk("rerun_pass", int'(if2.pass), 1);

      run(0, 1, edges, err0);
      chk("glitch_done_edge", edges, 24);
      dn = 1;
      repeat (6) begin
         @(negedge clk);
         if (if2.done) dn++;
      end
      chk("glitch_single_done", dn, 1);

      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outs", int'(act[0]), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("no_done_after_abort", int'(if2.done), 0);
      run(0, 0, edges, err0);
      chk("post_reset_done_edge", edges, 24);
      chk("post_reset_pass", int'(if2.pass), 1);

      start_v[0] = 1'b1;
      repeat (60) @(negedge clk);
      start_v[0] = 1'b0;
      repeat (30) @(negedge clk);

      run(1, 0, edges, err0);
      chk("s1_done_edge", edges, 16);
      chk("s1_pass", int'(if1.pass), 1);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
